// File: rtl/cic_decimator_if.sv
// Sample-strobe and data bundle for the CIC decimator.
// The master drives the strobes and input samples. The slave (the filter) returns the decimated output.
interface cic_decimator_if #(
  parameter int W = 10
);
  logic                eni;
  logic                eno;
  logic signed [W-1:0] in;
  logic signed [W-1:0] out;

  modport master (output eni, output eno, output in, input out);
  modport slave  (input eni, input eno, input in, output out);
endinterface

// File: rtl/cic_decimator.sv
// N-stage CIC decimator. The integrators advance on eni, and the combs and output advance on eno.
// The output is scaled by ATTN so that the DC gain is unity when R*M is a power of two.
module cic_decimator #(
  parameter int W = 10,
  parameter int R = 4,
  parameter int M = 2,
  parameter int N = 2
) (
  input  logic           clk,
  input  logic           rst,
  cic_decimator_if.slave bus
);
  localparam int GAIN = (R * M) ** N;
  localparam int DW   = W + $clog2(GAIN);
  localparam int ATTN = (2 ** (DW - 1)) / GAIN;
  localparam logic signed [2*DW-1:0] ATTN_W = (2*DW)'(ATTN);

  typedef logic [DW-1:0] word_t;

  word_t acc_q  [N];
  word_t acc_d  [N];
  word_t dec_q, dec_d;
  word_t dly_q  [N][M];
  word_t dly_d  [N][M];
  word_t comb_q [N];
  word_t comb_d [N];
  word_t comb_in [N];
  logic signed [2*DW-1:0] prod;
  logic [W-1:0] out_q, out_d;

  // NOTE: next-state logic uses blocking '=' in always_comb; only the always_ff below uses '<='.
  always_comb begin
    // NOTE: each _d is defaulted to its _q first, so no path leaves it unassigned and no latch is inferred.
    acc_d = acc_q;
    if (bus.eni) begin
      acc_d[0] = acc_q[0] + DW'($signed(bus.in));
      for (int k = 1; k < N; k++) acc_d[k] = acc_q[k] + acc_q[k-1];
    end
  end

  always_comb begin
    comb_in[0] = dec_q;
    for (int k = 1; k < N; k++) comb_in[k] = comb_q[k-1];
  end

  always_comb begin
    dec_d  = dec_q;
    dly_d  = dly_q;
    comb_d = comb_q;
    if (bus.eno) begin
      dec_d = acc_q[N-1];
      for (int k = 0; k < N; k++) begin
        dly_d[k][0] = comb_in[k];
        for (int i = 1; i < M; i++) dly_d[k][i] = dly_q[k][i-1];
        comb_d[k] = comb_in[k] - dly_q[k][M-1];
      end
    end
  end

  // Signed scaling by ATTN in Q1.(DW-1); arithmetic shift then keep the low W bits.
  always_comb begin
    prod  = $signed({{DW{comb_q[N-1][DW-1]}}, comb_q[N-1]}) * ATTN_W;
    out_d = out_q;
    if (bus.eno) out_d = W'(prod >>> (DW - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '{default: '0};
      dec_q  <= '0;
      // NOTE: the comb delay lines are cleared like ordinary flops, because a reset must discard all sample history.
      dly_q  <= '{default: '0};
      comb_q <= '{default: '0};
      out_q  <= '0;
    end else begin
      acc_q  <= acc_d;
      dec_q  <= dec_d;
      dly_q  <= dly_d;
      comb_q <= comb_d;
      out_q  <= out_d;
    end
  end

  assign bus.out = out_q;
endmodule

// File: tb/tb_cic_decimator.sv
// Self-checking bench for cic_decimator. The reference model captures unity DC gain, settling latency,
// strobe hold/freeze and reset behaviour, and the stimulus uses randomized DC levels and step phases.
module tb_cic_decimator;
  localparam int W = 10;
  localparam int R = 4;
  localparam int M = 2;
  localparam int N = 2;
  localparam int SETTLE = N * M + N + 2;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   phase  = 0;

  cic_decimator_if #(.W(W)) bus ();

  cic_decimator #(.W(W), .R(R), .M(M), .N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [W-1:0] got,
                       input logic signed [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic e_i, input logic e_o);
    bus.eni = e_i;
    bus.eno = e_o;
    @(posedge clk);
    #1;
  endtask

  // Nominal strobing: eni every clock, eno on every R-th eni.
  task automatic std_cycle(output bit was_eno);
    was_eno = (phase == R - 1);
    drive(1'b1, was_eno);
    phase = (phase + 1) % R;
  endtask

  // Apply a DC level and require out == level from the SETTLE-th eno onward.
  task automatic settle_check(input string tag, input int level, input int pulses);
    int seen = 0;
    bit e;
    bus.in = W'(level);
    while (seen < pulses) begin
      std_cycle(e);
      if (e) begin
        seen++;
        if (seen >= SETTLE) check(tag, bus.out, W'(level));
      end
    end
  endtask

  initial begin
    bit e;
    int lvl;
    rst     = 1'b1;
    bus.in  = W'(123);
    bus.eni = 1'b1;
    bus.eno = 1'b1;

    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1'b1);
      check("reset_out", bus.out, '0);
    end
    rst    = 1'b0;
    bus.in = '0;
    phase  = 0;
    for (int c = 0; c < 12 * R; c++) begin
      std_cycle(e);
      check("zero_after_reset", bus.out, '0);
    end

    settle_check("dc_8", 8, 12);
    settle_check("min_neg", -512, 12);
    settle_check("max_pos", 511, 12);
    settle_check("step_neg8", -8, 12);
    settle_check("dc_8_again", 8, 12);

    // Hold: eno idle while eni toggles; the output register must not move.
    for (int c = 0; c < 20; c++) begin
      drive(c[0], 1'b0);
      check("hold_eno_low", bus.out, W'(8));
    end
    settle_check("resettle_after_hold", 8, 12);

    // Freeze: no strobes and a different input, then resume with the same phase and no glitch.
    bus.in = W'(-300);
    for (int c = 0; c < 15; c++) begin
      drive(1'b0, 1'b0);
      check("freeze_out", bus.out, W'(8));
    end
    bus.in = W'(8);
    for (int c = 0; c < 12 * R; c++) begin
      std_cycle(e);
      if (e) check("freeze_resume", bus.out, W'(8));
    end

    // Mid-run reset, with the strobes still running.
    rst = 1'b1;
    std_cycle(e);
    check("midrun_reset", bus.out, '0);
    rst = 1'b0;
    settle_check("midrun_resettle", 8, 12);

    // Randomized DC levels, stepped at random clock phases.
    for (int t = 0; t < 8; t++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) std_cycle(e);
      lvl = int'($urandom_range(0, 1023)) - 512;
      settle_check("random_dc", lvl, 12);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cic_decimator.md
Name: cic_decimator

Overview:
- Fixed-point N-stage CIC (cascaded integrator-comb) decimating filter for the LPDAQ acquisition subsystem.
- Integrators run at the input sample strobe (eni). Combs run at the output sample strobe (eno).
- The output is gain-compensated so the DC gain is exactly 1 when R*M is a power of two.
- Input and output strobes come from an upstream modulo counter: a 1-cycle pulse every k clocks.

Parameters:
- W, 10: input/output sample width, signed two's complement.
- R, 4: decimation ratio, i.e. the number of eni strobes per eno strobe.
- M, 2: differential delay of each comb stage; must be at least 1.
- N, 2: number of integrator stages and number of comb stages.
- Derived GAIN = (R*M)^N. With defaults this is 64.
- Derived DW = W + ceil(log2(GAIN)). With defaults this is 16.
- Derived ATTN = floor(2^(DW-1) / GAIN), in Q1.(DW-1) format. With defaults this is 512.

Ports:
- clk, input, 1: single clock; all state updates on its rising edge.
- rst, input, 1: synchronous active-high reset; one clock, synchronous reset, active-high.
- eni, input, 1: input sample strobe; advances the integrators.
- eno, input, 1: output sample strobe; advances decimator, combs and output.
- in, input, W: signed input sample, sign-extended to DW internally.
- out, output, W: signed filtered and decimated sample, registered.

Behaviour:
- Reset: while rst=1 at a clock edge, the following clear to 0:
  - all integrator accumulators;
  - the decimation register;
  - all comb delay lines and comb outputs;
  - out.
- Reset has priority over both strobes. Reset in mid-stream discards all history.
- Integrator k (k = 1..N), on eni: acc_k <= acc_k + x_(k-1).
  - x_0 is the sign-extended input.
  - x_(k-1) for k > 1 is the registered acc_(k-1), so each stage adds one eni of pipeline delay.
  - Additions are modulo 2^DW (wrap-around is intended and harmless for CIC); no saturation.
- Decimation register, on eno: dec <= acc_N, sampling the value present before that edge's update.
- Comb k (k = 1..N), on eno, input c_(k-1) with c_0 = dec:
  - delay line d[0..M-1] shifts: d[0] <= c_(k-1), d[i] <= d[i-1];
  - c_k <= c_(k-1) - d[M-1], modulo 2^DW;
  - for M=1 the delay line is a single register.
- Output, on eno: out <= ((2*DW)-bit signed product c_N * ATTN) >>> (DW-1), truncated to its low W bits.
  - This is an arithmetic shift.
  - With power-of-two GAIN the result is exactly c_N / GAIN.
- Strobe timing:
  - With neither strobe asserted, all state holds.
  - If eni and eno are asserted in the same cycle, both update on that edge.
  - eno must coincide with an eni pulse, once every R eni pulses. Other strobe ratios are legal but change the gain to (ratio*M)^N; no error is flagged.
- Range: for any input in [-2^(W-1), 2^(W-1)-1], the settled DC output equals the input exactly. No overflow in out.
- Latency: the settled response to a DC step is reached by the (N*M + N + 2)-th eno pulse after the step, and is constant thereafter.

Test Plan:
- Reset: rst=1 for 3 cycles with in=123 and strobes active -> out=0 throughout. After release with in=0, out stays 0.
- DC gain: eni=1 every cycle, eno on every 4th cycle, in=8 -> out settles to exactly 8 by the 8th eno pulse and remains 8.
- Extremes: same strobes.
  - in=-512 -> out settles to -512.
  - Then in=511 -> out settles to 511; no wrap glitch in the settled value.
- Step: in steps 8 -> -8 -> out transitions and settles to -8 within 8 eno pulses. Integrator wrap-around occurs without affecting the result.
- Hold: eno=0 for 20 cycles while eni toggles -> out unchanged. eni=0 and eno=0 -> all internal state frozen, out unchanged.
- Mid-run reset: assert rst for 1 cycle during DC=8 operation -> out=0 on the next cycle. Then re-settles to 8 with the same latency as from power-up.
